// File: rtl/extremum_pkg.sv
// Shared types for the extremum tracker: detection mode, control FSM states,
// history priming levels and mode decode helpers.
package extremum_pkg;

    typedef enum logic [1:0] {
        MODE_MAX  = 2'b00,
        MODE_MIN  = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        SEARCH     = 2'b01,
        REFRACTORY = 2'b10
    } state_e;

    // Two prior samples must exist before x[n-1] can be judged a turning point.
    localparam logic [1:0] PRIME_LEVEL = 2'd2;
    localparam logic [1:0] PRIME_SAT   = 2'd3;

    function automatic logic mode_allows_max(input mode_e m);
        return (m == MODE_MAX) || (m == MODE_BOTH);
    endfunction

    function automatic logic mode_allows_min(input mode_e m);
        return (m == MODE_MIN) || (m == MODE_BOTH);
    endfunction

endpackage

// File: rtl/refractory_counter.sv
// Counts LEN accepted samples after a start pulse; LEN of zero still consumes
// one accepted sample so the blanking period is never empty.
module refractory_counter #(
    parameter int unsigned LEN = 72
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_ce,
    output logic o_done_c,
    output logic o_active
);

    localparam int unsigned TARGET = (LEN == 0) ? 1 : LEN;
    localparam int unsigned CW     = $clog2(TARGET + 1);

    logic [CW-1:0] r_cnt;
    logic          r_active;

    assign o_done_c = r_active && i_ce && (r_cnt == CW'(TARGET - 1));
    assign o_active = r_active;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (o_done_c) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (r_active && i_ce) begin
            r_cnt    <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/extremum_tracker.sv
// Local extremum detector: finds thresholded peaks/troughs of a sample stream
// inside a search window, then blanks detection for a refractory period.
module extremum_tracker
    import extremum_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 11,
    parameter int unsigned REFRACT_LEN = 72,
    parameter int unsigned TS_WIDTH    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ce,
    input  logic                  i_win_active,
    input  logic [1:0]            i_mode,
    input  logic [DATA_WIDTH-2:0] i_threshold,
    input  logic [DATA_WIDTH-1:0] i_signal,
    input  logic                  i_signal_valid,
    output logic                  o_extremum_valid,
    output logic                  o_extremum_is_max,
    output logic [DATA_WIDTH-1:0] o_extremum_value,
    output logic [TS_WIDTH-1:0]   o_extremum_ts,
    output logic                  o_refractory_active
);

    localparam int unsigned XW = DATA_WIDTH + 1;
    localparam logic signed [XW-1:0] ZERO = '0;

    state_e r_state;
    state_e w_state_next;

    logic [DATA_WIDTH-1:0] r_x1;
    logic [DATA_WIDTH-1:0] r_x2;
    logic [TS_WIDTH-1:0]   r_ts_cnt;
    logic [TS_WIDTH-1:0]   r_ts1;
    logic [1:0]            r_prime;

    logic                  r_valid;
    logic                  r_is_max;
    logic [DATA_WIDTH-1:0] r_value;
    logic [TS_WIDTH-1:0]   r_ts;

    logic  w_accept;
    logic  w_primed;
    logic  w_cand_max;
    logic  w_cand_min;
    logic  w_detect;
    logic  w_det_is_max;
    logic  w_refr_done;
    logic  w_refr_active;
    mode_e w_mode;

    logic signed [XW-1:0] w_x0_e;
    logic signed [XW-1:0] w_x1_e;
    logic signed [XW-1:0] w_x2_e;
    logic signed [XW-1:0] w_d_n;
    logic signed [XW-1:0] w_d_p;
    logic signed [XW-1:0] w_thr_pos;
    logic signed [XW-1:0] w_thr_neg;

    assign w_accept = i_ce && i_signal_valid;
    assign w_mode   = mode_e'(i_mode);
    assign w_primed = (r_prime >= PRIME_LEVEL);

    // One extra bit keeps both slopes and the negated threshold exact.
    assign w_x0_e    = {i_signal[DATA_WIDTH-1], i_signal};
    assign w_x1_e    = {r_x1[DATA_WIDTH-1], r_x1};
    assign w_x2_e    = {r_x2[DATA_WIDTH-1], r_x2};
    assign w_d_n     = w_x0_e - w_x1_e;
    assign w_d_p     = w_x1_e - w_x2_e;
    assign w_thr_pos = {2'b00, i_threshold};
    assign w_thr_neg = -w_thr_pos;

    assign w_cand_max = w_primed && (w_d_p > ZERO) && (w_d_n <= ZERO)
                        && (w_x1_e >= w_thr_pos) && mode_allows_max(w_mode);
    assign w_cand_min = w_primed && (w_d_p < ZERO) && (w_d_n >= ZERO)
                        && (w_x1_e <= w_thr_neg) && mode_allows_min(w_mode);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_detect     = 1'b0;
        w_det_is_max = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_ce && i_win_active) begin
                    w_state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (w_accept && i_win_active && (w_cand_max || w_cand_min)) begin
                    w_detect     = 1'b1;
                    w_det_is_max = w_cand_max;
                    w_state_next = REFRACTORY;
                end else if (i_ce && !i_win_active) begin
                    w_state_next = IDLE;
                end
            end
            REFRACTORY: begin
                if (w_refr_done) begin
                    w_state_next = i_win_active ? SEARCH : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Sample history, timestamps and the held detection report.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x1     <= '0;
            r_x2     <= '0;
            r_ts_cnt <= '0;
            r_ts1    <= '0;
            r_prime  <= '0;
            r_valid  <= 1'b0;
            r_is_max <= 1'b0;
            r_value  <= '0;
            r_ts     <= '0;
        end else begin
            r_valid <= w_detect;
            if (w_detect) begin
                r_is_max <= w_det_is_max;
                r_value  <= r_x1;
                r_ts     <= r_ts1;
            end
            if (w_accept) begin
                r_x2     <= r_x1;
                r_x1     <= i_signal;
                r_ts1    <= r_ts_cnt;
                r_ts_cnt <= r_ts_cnt + TS_WIDTH'(1);
                if (r_prime != PRIME_SAT) begin
                    r_prime <= r_prime + 2'd1;
                end
            end
        end
    end

    refractory_counter #(
        .LEN(REFRACT_LEN)
    ) u_refr (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (w_detect),
        .i_ce     (w_accept),
        .o_done_c (w_refr_done),
        .o_active (w_refr_active)
    );

    assign o_extremum_valid    = r_valid;
    assign o_extremum_is_max   = r_is_max;
    assign o_extremum_value    = r_value;
    assign o_extremum_ts       = r_ts;
    assign o_refractory_active = w_refr_active;

endmodule
